// File: rtl/mc_control_unit.sv
// Multi-cycle sequencer for the 32-bit datapath: fetch, decode, execute, memory, writeback.
// Outputs depend only on the state register and the instruction register.
module mc_control_unit #(
  parameter logic [4:0] ALU_ADD = 5'd0,
  parameter logic [4:0] OP_HALT = 5'b11111
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] ins,
  input  logic [2:0]  comp_res,
  output logic        en,
  output logic        read,
  output logic        write,
  output logic        writeport,
  output logic        writedata,
  output logic        src1,
  output logic        src2,
  output logic        selcomp,
  output logic [4:0]  alu_func,
  output logic        ld_lmd,
  output logic        en_data_mem,
  output logic        wri_data_mem,
  output logic        en_ins_mem,
  output logic        load_ir,
  output logic        ld_pc,
  output logic [1:0]  selsig,
  output logic        selPC,
  output logic        isbranch,
  output logic        resetPC,
  output logic        reset_all,
  output logic        halted,
  output logic [31:0] instr_count
);

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00001;
  localparam logic [4:0] OP_LW   = 5'b00010;
  localparam logic [4:0] OP_SW   = 5'b00011;
  localparam logic [4:0] OP_BEQ  = 5'b00100;
  localparam logic [4:0] OP_BLT  = 5'b00101;
  localparam logic [4:0] OP_BGT  = 5'b00110;
  localparam logic [4:0] OP_BEQZ = 5'b00111;
  localparam logic [4:0] OP_J    = 5'b01000;
  localparam logic [4:0] OP_JAL  = 5'b01001;

  typedef enum logic [3:0] {
    S_RST, S_IDLE, S_IF1, S_IF2, S_ID, S_EX, S_MEM, S_LMD, S_WB, S_HALT
  } state_t;

  state_t state, state_nxt;

  logic [4:0] opcode;
  logic       is_lw, is_sw, is_halt;
  logic       d_wr, d_wp, d_wd, d_s1, d_s2, d_sc, d_spc, d_ib;
  logic [4:0] d_af;
  logic [1:0] d_ss;

  assign opcode  = ins[31:27];
  assign is_lw   = (opcode == OP_LW);
  assign is_sw   = (opcode == OP_SW);
  assign is_halt = (opcode == OP_HALT);

  // Comparator flags and immediate bits are consumed by the datapath only.
  logic unused_ok;
  assign unused_ok = ^{comp_res, ins[26:5]};

  always_comb begin
    d_wr  = 1'b0;
    d_wp  = 1'b0;
    d_wd  = 1'b0;
    d_s1  = 1'b0;
    d_s2  = 1'b0;
    d_sc  = 1'b0;
    d_af  = ALU_ADD;
    d_ss  = 2'b00;
    d_spc = 1'b0;
    d_ib  = 1'b0;
    case (opcode)
      OP_R:    begin d_wp = 1'b1; d_af = ins[4:0]; d_wr = 1'b1; end
      OP_ADDI: begin d_s2 = 1'b1; d_wr = 1'b1; end
      OP_LW:   begin d_s2 = 1'b1; d_wd = 1'b1; d_wr = 1'b1; end
      OP_SW:   d_s2 = 1'b1;
      OP_BEQ:  begin d_s1 = 1'b1; d_s2 = 1'b1; d_ss = 2'b10; end
      OP_BLT:  begin d_s1 = 1'b1; d_s2 = 1'b1; d_ss = 2'b01; end
      OP_BGT:  begin d_s1 = 1'b1; d_s2 = 1'b1; d_ss = 2'b11; end
      OP_BEQZ: begin d_s1 = 1'b1; d_s2 = 1'b1; d_ss = 2'b10; d_sc = 1'b1; end
      OP_J:    begin d_s1 = 1'b1; d_s2 = 1'b1; d_spc = 1'b1; end
      OP_JAL:  begin d_s1 = 1'b1; d_s2 = 1'b1; d_spc = 1'b1; d_ib = 1'b1; d_wr = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_RST;
      instr_count <= 32'd0;
    end else begin
      state <= state_nxt;
      if (state == S_WB) instr_count <= instr_count + 32'd1;
    end
  end

  always_comb begin
    state_nxt    = state;
    en           = 1'b0;
    read         = 1'b0;
    write        = 1'b0;
    writeport    = 1'b0;
    writedata    = 1'b0;
    src1         = 1'b0;
    src2         = 1'b0;
    selcomp      = 1'b0;
    alu_func     = 5'd0;
    ld_lmd       = 1'b0;
    en_data_mem  = 1'b0;
    wri_data_mem = 1'b0;
    en_ins_mem   = 1'b0;
    load_ir      = 1'b0;
    ld_pc        = 1'b0;
    selsig       = 2'b00;
    selPC        = 1'b0;
    isbranch     = 1'b0;
    resetPC      = 1'b0;
    reset_all    = 1'b0;
    halted       = 1'b0;
    // Operand selects and next-PC controls are held from EX through WB.
    if (state == S_EX || state == S_MEM || state == S_LMD || state == S_WB) begin
      writeport = d_wp;
      writedata = d_wd;
      src1      = d_s1;
      src2      = d_s2;
      selcomp   = d_sc;
      alu_func  = d_af;
      selsig    = d_ss;
      selPC     = d_spc;
      isbranch  = d_ib;
    end
    case (state)
      S_RST: begin
        resetPC   = 1'b1;
        reset_all = 1'b1;
        state_nxt = S_IDLE;
      end
      S_IDLE: if (start) state_nxt = S_IF1;
      S_IF1: begin
        en_ins_mem = 1'b1;
        state_nxt  = S_IF2;
      end
      S_IF2: begin
        en_ins_mem = 1'b1;
        load_ir    = 1'b1;
        state_nxt  = S_ID;
      end
      S_ID: begin
        en        = 1'b1;
        read      = 1'b1;
        state_nxt = S_EX;
      end
      S_EX: begin
        en   = 1'b1;
        read = 1'b1;
        if (is_halt)             state_nxt = S_HALT;
        else if (is_lw || is_sw) state_nxt = S_MEM;
        else                     state_nxt = S_WB;
      end
      S_MEM: begin
        en_data_mem  = 1'b1;
        wri_data_mem = is_sw;
        state_nxt    = is_lw ? S_LMD : S_WB;
      end
      S_LMD: begin
        ld_lmd    = 1'b1;
        state_nxt = S_WB;
      end
      S_WB: begin
        ld_pc     = 1'b1;
        write     = d_wr;
        en        = d_wr;
        state_nxt = S_IF1;
      end
      S_HALT: halted = 1'b1;
      default: state_nxt = S_RST;
    endcase
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: directed instruction sequence with a writeback scoreboard.
module tb_mc_control_unit;

  logic        clk = 1'b0;
  logic        reset_n, start;
  logic [31:0] ins;
  logic [2:0]  comp_res;
  logic        en, read, write, writeport, writedata, src1, src2, selcomp;
  logic [4:0]  alu_func;
  logic        ld_lmd, en_data_mem, wri_data_mem, en_ins_mem, load_ir, ld_pc;
  logic [1:0]  selsig;
  logic        selPC, isbranch, resetPC, reset_all, halted;
  logic [31:0] instr_count;

  mc_control_unit dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ins(ins), .comp_res(comp_res),
    .en(en), .read(read), .write(write), .writeport(writeport), .writedata(writedata),
    .src1(src1), .src2(src2), .selcomp(selcomp), .alu_func(alu_func),
    .ld_lmd(ld_lmd), .en_data_mem(en_data_mem), .wri_data_mem(wri_data_mem),
    .en_ins_mem(en_ins_mem), .load_ir(load_ir), .ld_pc(ld_pc), .selsig(selsig),
    .selPC(selPC), .isbranch(isbranch), .resetPC(resetPC), .reset_all(reset_all),
    .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          wb_cyc;
    int          mem_cyc;
    int          lmd_cyc;
    logic [14:0] ctrl;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  int          last_mem = -1;
  int          last_lmd = -1;
  logic [31:0] exp_cnt = 32'd0;

  wire [14:0] ctrl_now = {write, writeport, writedata, src1, src2, selcomp,
                          alu_func, selsig, selPC, isbranch};
  wire [23:0] others = {en, read, write, writeport, writedata, src1, src2, selcomp,
                        alu_func, ld_lmd, en_data_mem, wri_data_mem, en_ins_mem,
                        load_ir, ld_pc, selsig, selPC, isbranch, halted};

  function automatic logic [14:0] mk(input logic wr, wp, wd, s1, s2, sc,
                                     input logic [4:0] af, input logic [1:0] ss,
                                     input logic spc, ib);
    return {wr, wp, wd, s1, s2, sc, af, ss, spc, ib};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ld_pc pulse is a retiring writeback and pops one expectation.
  always @(negedge clk) begin
    if (wri_data_mem) last_mem = cyc;
    if (ld_lmd) last_lmd = cyc;
    if (write) chk("write_outside_wb", {31'd0, ld_pc}, 32'd1);
    if (ld_pc) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_wb: got ld_pc=1 expected no writeback (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("wb_cycle", mon_e.wb_cyc, cyc);
        chk("wb_ctrl", {17'd0, ctrl_now}, {17'd0, mon_e.ctrl});
        chk("wb_count", instr_count, mon_e.cnt);
        chk("mem_write_cycle", last_mem, mon_e.mem_cyc);
        chk("lmd_cycle", last_lmd, mon_e.lmd_cyc);
      end
      last_mem = -1;
      last_lmd = -1;
    end
  end

  task automatic wait_if1(output bit got);
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (halted || (en_ins_mem && !load_ir)) got = 1'b1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL timeout: got no IF1/HALT within 12 cycles expected one (cycle %0d)", cyc);
    end
  endtask

  // Called at the negedge of IF1; leaves the bench at the next IF1 or HALT negedge.
  task automatic run_instr(input logic [31:0] iv, input logic [2:0] cr,
                           input logic [14:0] ctrl, input int len,
                           input int mem_off, input int lmd_off, input bit is_halt);
    exp_t e;
    int   k;
    bit   got;
    chk("if1_state", {30'd0, en_ins_mem, load_ir}, 32'd2);
    k = cyc;
    if (!is_halt) begin
      e.wb_cyc  = k + len - 1;
      e.mem_cyc = (mem_off < 0) ? -1 : k + mem_off;
      e.lmd_cyc = (lmd_off < 0) ? -1 : k + lmd_off;
      e.ctrl    = ctrl;
      e.cnt     = exp_cnt;
      sb.push_back(e);
      exp_cnt   = exp_cnt + 32'd1;
    end
    @(negedge clk);
    chk("if2_load_ir", {31'd0, load_ir}, 32'd1);
    @(posedge clk);
    #1 ins = iv;
    comp_res = cr;
    wait_if1(got);
    if (is_halt) begin
      chk("halt_cycle", cyc - k, 32'd4);
      chk("halted", {31'd0, halted}, 32'd1);
    end
    chk("count_after", instr_count, exp_cnt);
  endtask

  initial begin
    int rel;
    int strobes;
    bit got;
    reset_n  = 1'b0;
    start    = 1'b0;
    ins      = 32'd0;
    comp_res = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_clear", {30'd0, resetPC, reset_all}, 32'd3);
    chk("reset_others", {8'd0, others}, 32'd0);
    chk("reset_count", instr_count, 32'd0);

    start   = 1'b1;
    reset_n = 1'b1;
    rel     = cyc;
    @(negedge clk);
    chk("rst_cycle", {30'd0, resetPC, reset_all}, 32'd3);
    @(negedge clk);
    chk("idle_cycle", {29'd0, resetPC, reset_all, en_ins_mem}, 32'd0);
    @(negedge clk);
    chk("if1_latency", {31'd0, en_ins_mem}, 32'd1);
    chk("if1_cycle", cyc - rel, 32'd2);

    run_instr(32'h0010_8001, 3'b000, mk(1,1,0,0,0,0,5'd1,2'b00,0,0), 5, -1, -1, 0);
    run_instr(32'h1000_0004, 3'b000, mk(1,0,1,0,1,0,5'd0,2'b00,0,0), 7, -1,  5, 0);
    run_instr(32'h1800_0008, 3'b000, mk(0,0,0,0,1,0,5'd0,2'b00,0,0), 6,  4, -1, 0);
    run_instr(32'h2000_0010, 3'b010, mk(0,0,0,1,1,0,5'd0,2'b10,0,0), 5, -1, -1, 0);
    run_instr(32'h2800_0010, 3'b100, mk(0,0,0,1,1,0,5'd0,2'b01,0,0), 5, -1, -1, 0);
    run_instr(32'h3000_0010, 3'b001, mk(0,0,0,1,1,0,5'd0,2'b11,0,0), 5, -1, -1, 0);
    run_instr(32'h3800_0010, 3'b010, mk(0,0,0,1,1,1,5'd0,2'b10,0,0), 5, -1, -1, 0);
    run_instr(32'h4000_0020, 3'b000, mk(0,0,0,1,1,0,5'd0,2'b00,1,0), 5, -1, -1, 0);
    run_instr(32'h4800_0020, 3'b000, mk(1,0,0,1,1,0,5'd0,2'b00,1,1), 5, -1, -1, 0);
    run_instr(32'h0800_0003, 3'b000, mk(1,0,0,0,1,0,5'd0,2'b00,0,0), 5, -1, -1, 0);
    run_instr(32'h5000_001F, 3'b000, mk(0,0,0,0,0,0,5'd0,2'b00,0,0), 5, -1, -1, 0);
    run_instr(32'hF800_0000, 3'b000, 15'd0, 5, -1, -1, 1);

    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    repeat (3) @(negedge clk);
    chk("halt_sticky", {30'd0, halted, en_ins_mem}, 32'd2);
    chk("halt_count", instr_count, 32'd11);

    // Abort an LW in MEM with an asynchronous reset.
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    ins = 32'd0;
    wait_if1(got);
    chk("abort_if1", {31'd0, en_ins_mem}, 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1 ins = 32'h1000_0004;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (en_data_mem) got = 1'b1;
    end
    chk("abort_reached_mem", {31'd0, got}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_async_clear", {30'd0, resetPC, reset_all}, 32'd3);
    chk("abort_async_others", {8'd0, others}, 32'd0);
    strobes = 0;
    repeat (6) begin
      @(negedge clk);
      if (write || wri_data_mem || ld_pc) strobes++;
    end
    chk("abort_no_strobe", strobes, 32'd0);
    chk("abort_count", instr_count, 32'd0);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multi-cycle FSM controller that drives every control input of the 32-bit datapath.
- Consumes the registered instruction (`out_ins`) and comparator flags (`comp_res`) and sequences fetch / decode / execute / memory / writeback.
- Pairs one-to-one with the datapath in the CPU top level.

Parameters:
- ALU_ADD, 5'd0, alu_func code for add, used for address and branch-target computation.
- OP_HALT, 5'b11111, opcode that stops the machine.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  level; leaves IDLE when high.
- ins  in  32  registered instruction. Opcode = ins[31:27]; R-type function = ins[4:0].
- comp_res  in  3  {gt, eq, lt} from the comparator.
- en, read, write  out  1 each  register-bank enable, read, write.
- writeport  out  1  1 = dest is rd, 0 = dest is rt.
- writedata  out  1  1 = LMD value, 0 = ALU Z.
- src1  out  1  1 = ALU A is npc, 0 = rs.
- src2  out  1  1 = ALU B is sign-extended imm, 0 = rt.
- selcomp  out  1  1 = compare rs against 0, 0 = compare against rt.
- alu_func  out  5  ALU operation.
- ld_lmd, en_data_mem, wri_data_mem, en_ins_mem, load_ir, ld_pc  out  1 each  datapath strobes.
- selsig  out  2  next-PC condition: 00 = selPC, 01 = lt, 10 = eq, 11 = gt.
- selPC  out  1  unconditional-jump flag (used when selsig = 00).
- isbranch  out  1  link: write npc into R15.
- resetPC, reset_all  out  1 each  synchronous datapath clear.
- halted  out  1  high in HALT.
- instr_count  out  32  retired-instruction counter.

Behaviour:
- All control outputs are Moore outputs of state plus decoded `ins`; they are registered-state driven, with no combinational path from `comp_res`.
- Reset (reset_n = 0):
  - state = RST; instr_count = 0.
  - resetPC = reset_all = 1; every other output is 0.
- RST: one cycle, resetPC = reset_all = 1, then go to IDLE.
- IDLE: all strobes 0. Go to IF1 when start = 1.
- IF1: en_ins_mem = 1.
- IF2: en_ins_mem = 1, load_ir = 1.
- ID: en = read = 1. Opcode is decoded from `ins`, which is stable from here.
- EX: en = read = 1. src1, src2, selcomp and alu_func are set per opcode and held through MEM, LMD and WB.
  - LW and SW go to MEM; all others go to WB.
  - OP_HALT goes to HALT without retiring.
- MEM: en_data_mem = 1; wri_data_mem = 1 for SW only.
  - LW goes to LMD; SW goes to WB.
- LMD: ld_lmd = 1, then go to WB.
- WB:
  - ld_pc = 1.
  - write = 1 for ALU, ADDI, LW and JAL.
  - instr_count increments, wrapping 32'hFFFFFFFF to 0.
  - Next state is IF1.
  - The next-PC choice is made in this cycle, so the link write and the PC load use the same npc.
- HALT: halted = 1, all strobes 0; leave only via reset_n.
- Opcode decode:
  - 00000 R-type: writeport = 1, src1 = 0, src2 = 0, alu_func = ins[4:0].
  - 00001 ADDI: writeport = 0 (rt), src2 = 1, alu_func = ALU_ADD.
  - 00010 LW: src2 = 1, ALU_ADD, writedata = 1, writeport = 0.
  - 00011 SW: src2 = 1, ALU_ADD, no register write.
  - 00100 BEQ / 00101 BLT / 00110 BGT: src1 = 1, src2 = 1, ALU_ADD; target = npc + imm; selsig = 10 / 01 / 11; selcomp = 0.
  - 00111 BEQZ: as BEQ with selcomp = 1.
  - 01000 J: src1 = 1, src2 = 1, ALU_ADD, selsig = 00, selPC = 1.
  - 01001 JAL: as J plus isbranch = 1, write = 1 in WB.
  - Any other opcode is a NOP: PC advances to npc, no write, instruction is counted.
- For non-branch instructions selsig = 00 and selPC = 0, so the next PC is npc.
- Latency:
  - ALU / ADDI / branch / jump: 5 cycles.
  - SW: 6 cycles.
  - LW: 7 cycles.
- reset_n asserted in any state aborts immediately: no ld_pc, write or wri_data_mem pulse may follow it.
- start is ignored outside IDLE.

Test Plan:
- Reset, then release with start = 1 → one RST cycle (resetPC = reset_all = 1), IDLE, then en_ins_mem high in IF1 on the 3rd cycle after release.
- R-type ins = 32'h0010_8001 (function 1) → alu_func = 1, writeport = 1, write = 1 and ld_pc = 1 only in cycle 5 of the instruction; instr_count 0 → 1.
- LW then SW back-to-back → LW: ld_lmd in cycle 6, write with writedata = 1 in cycle 7. SW: wri_data_mem = 1 in cycle 5, no write. instr_count = 2 after 13 cycles.
- BEQ with comp_res = 3'b010 → selsig = 10, src1 = src2 = 1 through WB. Same with BLT and comp_res = 3'b100 → selsig = 01, which the datapath does not take.
- JAL → isbranch = 1, write = 1, ld_pc = 1 in the same WB cycle; selPC = 1, selsig = 00.
- OP_HALT → halted = 1 after EX with instr_count unchanged. Assert reset_n low mid-LW in MEM → outputs go to reset values asynchronously, no wri_data_mem or write pulse follows.
